// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM state type,
// requester count, beat-counter width and the small combinational helpers
// used by the controller.
package rr_arb4_pkg;

  // Number of requesters served by the arbiter.
  localparam int NREQ = 4;

  // Width of the per-grant beat counter. It is wide enough for MAX_HOLD up to 15.
  localparam int CNT_W = 4;

  // Controller states: waiting for a request, or serving one requester.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin pick. Scan ptr, ptr+1, ... (mod 4) and return the first index
  // whose request bit is set. The loop runs from the farthest candidate to the
  // nearest, so the nearest set bit overwrites the others. If no bit is set,
  // the result is ptr. Callers only use the result when req is nonzero.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // One-hot decode of a requester index. It drives the ack vector.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Bus bundle between the requesters/downstream sink and the arbiter.
// The master side is the environment: it drives requests, data and
// dout_ready. The slave side is the arbiter: it answers with ack, sel,
// dout, dout_valid and busy.
interface rr_arb4_if
  import rr_arb4_pkg::*;
#(
  parameter int W = 8
);

  logic [NREQ-1:0] req;
  logic [W-1:0]    din_0;
  logic [W-1:0]    din_1;
  logic [W-1:0]    din_2;
  logic [W-1:0]    din_3;
  logic [NREQ-1:0] ack;
  logic [1:0]      sel;
  logic [W-1:0]    dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            busy;

  modport master (
    output req,
    output din_0,
    output din_1,
    output din_2,
    output din_3,
    output dout_ready,
    input  ack,
    input  sel,
    input  dout,
    input  dout_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  din_0,
    input  din_1,
    input  din_2,
    input  din_3,
    input  dout_ready,
    output ack,
    output sel,
    output dout,
    output dout_valid,
    output busy
  );

endinterface

// File: rtl/rr_arb4_mux.sv
// W-bit 4:1 data selector for the arbiter. When en is low (no grant active),
// the output is forced to zero so that no stale requester data leaks
// downstream.
module rr_arb4_mux
  import rr_arb4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] din_0,
  input  logic [W-1:0] din_1,
  input  logic [W-1:0] din_2,
  input  logic [W-1:0] din_3,
  input  logic [1:0]   sel,
  input  logic         en,
  output logic [W-1:0] dout
);

  // Route the granted requester's data, or zeros when no grant is active.
  always_comb begin
    dout = {W{1'b0}};
    if (en) begin
      case (sel)
        2'd0:    dout = din_0;
        2'd1:    dout = din_1;
        2'd2:    dout = din_2;
        2'd3:    dout = din_3;
        default: dout = {W{1'b0}};
      endcase
    end else begin
      dout = {W{1'b0}};
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with bounded grant length.
//
// IDLE picks the next requester, starting the round-robin scan at ptr. It
// registers the choice into sel, so arbitration costs one cycle. GRANT then
// streams beats from that requester until one of two things happens: the
// requester drops its request, or MAX_HOLD beats have transferred. In either
// case the FSM returns to IDLE for exactly one cycle. ptr then advances past
// the requester that just finished, which gives fairness across requesters.
//
// A holder that keeps requesting while downstream stalls keeps the grant
// indefinitely. There is no timeout.
//
// MAX_HOLD is meant to lie in 1..15 so that it fits the 4-bit beat counter.
//
// All data steering lives in rr_arb4_mux. This module only handles control.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  rr_arb4_if.slave    bus
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       ptr_r;
  logic [1:0]       next_ptr_s;
  logic [1:0]       sel_r;
  logic [1:0]       next_sel_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;

  logic             grant_s;
  logic             valid_s;
  logic             xfer_s;
  logic [NREQ-1:0]  ack_s;
  logic [W-1:0]     dout_s;

  // State register. Reset aborts any grant immediately and restarts the
  // round-robin scan from requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      ptr_r   <= next_ptr_s;
      sel_r   <= next_sel_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, then count beats and detect
  // release in GRANT.
  always_comb begin
    next_state_s = state_r;
    next_ptr_s   = ptr_r;
    next_sel_s   = sel_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          next_sel_s   = rr_pick(bus.req, ptr_r);
          next_state_s = GRANT;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[sel_r]) begin
          // The holder withdrew. Release and move the pointer past it.
          next_state_s = IDLE;
          next_ptr_s   = sel_r + 2'd1;
          next_cnt_s   = {CNT_W{1'b0}};
        end else if (xfer_s) begin
          if ((cnt_r + 4'd1) == MAX_HOLD_C) begin
            // This beat uses up the holder's quota.
            next_state_s = IDLE;
            next_ptr_s   = sel_r + 2'd1;
            next_cnt_s   = {CNT_W{1'b0}};
          end else begin
            next_cnt_s   = cnt_r + 4'd1;
          end
        end else begin
          // Downstream stalled. Hold the grant and the count.
          next_state_s = GRANT;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_ptr_s   = 2'd0;
        next_sel_s   = 2'd0;
        next_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode. Valid, transfer and ack are combinational in GRANT, so a
  // beat is acknowledged in the same cycle that it moves.
  always_comb begin
    grant_s = (state_r == GRANT);
    valid_s = 1'b0;
    xfer_s  = 1'b0;
    ack_s   = 4'b0000;
    if (grant_s) begin
      valid_s = bus.req[sel_r];
      xfer_s  = bus.req[sel_r] & bus.dout_ready;
    end else begin
      valid_s = 1'b0;
      xfer_s  = 1'b0;
    end
    if (xfer_s) begin
      ack_s = onehot4(sel_r);
    end else begin
      ack_s = 4'b0000;
    end
  end

  rr_arb4_mux #(
    .W (W)
  ) u_mux (
    .din_0 (bus.din_0),
    .din_1 (bus.din_1),
    .din_2 (bus.din_2),
    .din_3 (bus.din_3),
    .sel   (sel_r),
    .en    (grant_s),
    .dout  (dout_s)
  );

  assign bus.ack        = ack_s;
  assign bus.sel        = sel_r;
  assign bus.dout       = dout_s;
  assign bus.dout_valid = valid_s;
  assign bus.busy       = grant_s;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4.
// Stimulus pushes the beats it expects into exp_q. A negedge monitor pops
// and compares each time the DUT acknowledges a transfer. Control-state
// observations (busy, sel, idle gaps) are checked inline.
module tb_rr_arb4;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] dout;
  } beat_t;

  logic       clk;
  logic       reset;
  logic [7:0] din_v [4];
  int         checks;
  int         failures;
  beat_t      exp_q [$];

  rr_arb4_if #(.W(8)) bus ();

  rr_arb4 #(
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.din_0 = din_v[0];
  assign bus.din_1 = din_v[1];
  assign bus.din_2 = din_v[2];
  assign bus.din_3 = din_v[3];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge in the middle of the current cycle.
  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every ack must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (bus.ack !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=%b sel=%0d, expected no transfer (t=%0t)",
                 bus.ack, bus.sel, $time);
      end else begin
        e = exp_q.pop_front();
        check("beat_ack", 32'(bus.ack), 32'(e.ack));
        check("beat_sel", 32'(bus.sel), 32'(e.sel));
        check("beat_dout", 32'(bus.dout), 32'(e.dout));
        check("beat_valid", 32'(bus.dout_valid), 32'd1);
      end
    end
  end

  // One full grant of 4 beats to requester s, with the release checked
  // afterwards. On entry the current cycle is an IDLE arbitration cycle with
  // req already set. On exit the bench sits at the negedge of the following
  // one-cycle IDLE gap.
  task automatic burst(input logic [1:0] s);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.ack  = 4'b0001 << s;
      b.sel  = s;
      b.dout = din_v[s];
      exp_q.push_back(b);
    end
    cyc();
    mid();
    check("grant_busy", 32'(bus.busy), 32'd1);
    check("grant_sel", 32'(bus.sel), 32'(s));
    check("grant_valid", 32'(bus.dout_valid), 32'd1);
    repeat (4) cyc();
    mid();
    check("gap_busy", 32'(bus.busy), 32'd0);
    check("gap_valid", 32'(bus.dout_valid), 32'd0);
    check("gap_dout", 32'(bus.dout), 32'd0);
    check("gap_ack", 32'(bus.ack), 32'd0);
  endtask

  task automatic set_din_tagged();
    for (int i = 0; i < 4; i++) din_v[i] = 8'hC0 + 8'(i);
  endtask

  // Watchdog: guarantees the run ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] base;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req        = 4'b0000;
    bus.dout_ready = 1'b0;
    set_din_tagged();

    // Reset state.
    repeat (2) cyc();
    mid();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    cyc();
    reset = 1'b0;

    // Single requester 2: a full grant, one IDLE cycle, then a re-grant to 2.
    bus.req        = 4'b0100;
    bus.dout_ready = 1'b1;
    mid();
    check("arb_cycle_busy", 32'(bus.busy), 32'd0);
    burst(2'd2);
    burst(2'd2);
    bus.req = 4'b0000;
    cyc();

    // ptr is now 3. With req=1001 the grant goes to 3, then ptr wraps and the
    // next grant goes to 0.
    bus.req = 4'b1001;
    burst(2'd3);
    burst(2'd0);
    bus.req = 4'b0000;
    cyc();

    // Reset, then all four requesting: order 0,1,2,3,0 with din_i = i*0x11.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    base = 8'h11;
    for (int i = 0; i < 4; i++) din_v[i] = base * 8'(i);
    bus.req = 4'b1111;
    burst(2'd0);
    burst(2'd1);
    burst(2'd2);
    burst(2'd3);
    burst(2'd0);
    bus.req = 4'b0000;
    cyc();

    // ptr is now 1. Grant to 1, stall for 10 cycles, then the requester withdraws.
    set_din_tagged();
    bus.req        = 4'b0010;
    bus.dout_ready = 1'b0;
    cyc();
    mid();
    check("stall_grant_sel", 32'(bus.sel), 32'd1);
    check("stall_grant_valid", 32'(bus.dout_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      mid();
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_ack", 32'(bus.ack), 32'd0);
    end
    cyc();
    bus.req = 4'b0000;
    #1;
    check("withdraw_valid", 32'(bus.dout_valid), 32'd0);
    check("withdraw_busy", 32'(bus.busy), 32'd1);
    mid();
    check("withdraw_ack", 32'(bus.ack), 32'd0);
    cyc();
    mid();
    check("withdraw_idle", 32'(bus.busy), 32'd0);
    // ptr is now 2, so req=0011 is scanned 2,3,0,1 and the grant goes to 0.
    bus.req        = 4'b0011;
    bus.dout_ready = 1'b1;
    burst(2'd0);
    bus.req = 4'b0000;
    cyc();

    // Asynchronous reset mid-grant, after 2 beats from requester 2.
    bus.req = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      beat_t b;
      b.ack  = 4'b0100;
      b.sel  = 2'd2;
      b.dout = din_v[2];
      exp_q.push_back(b);
    end
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_ack", 32'(bus.ack), 32'd0);
    check("async_rst_valid", 32'(bus.dout_valid), 32'd0);
    check("async_rst_dout", 32'(bus.dout), 32'd0);
    check("async_rst_sel", 32'(bus.sel), 32'd0);
    mid();
    cyc();
    reset   = 1'b0;
    bus.req = 4'b0010;
    burst(2'd1);
    bus.req = 4'b0000;
    cyc();
    cyc();

    check("leftover_expected_beats", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter W, default 8, data width per requester.
REQ-002 Parameter MAX_HOLD, default 4, maximum beats per grant, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester request; bit i set means din_i holds a valid beat.
REQ-006 din_0, din_1, din_2, din_3  input  W each  requester data.
REQ-007 ack  output  4  one-hot; bit i high for one cycle when a beat from requester i transfers.
REQ-008 sel  output  2  index of the currently granted requester.
REQ-009 dout  output  W  selected data.
REQ-010 dout_valid  output  1  dout holds a beat.
REQ-011 dout_ready  input  1  downstream accepts dout this cycle.
REQ-012 busy  output  1  high in GRANT state.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 In IDLE with req nonzero, the block SHALL choose the first set req bit scanning ptr, ptr+1, ... mod 4; it SHALL register that index into sel and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-015 In IDLE with req zero, the block SHALL stay in IDLE; sel, ptr and beat count SHALL remain unchanged.
REQ-016 In GRANT, dout SHALL equal din_sel combinationally, and dout_valid SHALL equal req[sel].
REQ-017 Outside GRANT, dout_valid SHALL be 0 and dout SHALL be all zeros.
REQ-018 A transfer SHALL occur in each cycle where GRANT, dout_valid and dout_ready are all high.
REQ-019 On a transfer, ack[sel] SHALL be 1 in the same cycle, and the beat counter SHALL increment at the following edge.
REQ-020 ack SHALL be zero in every cycle without a transfer; ack SHALL never have more than one bit set.
REQ-021 GRANT SHALL end, returning to IDLE at the next edge, when either condition holds:
  - req[sel] is low (requester withdrew), or
  - a transfer occurs that makes the beat count equal MAX_HOLD.
REQ-022 On leaving GRANT, ptr SHALL become (sel+1) mod 4, wrapping 3 to 0, and the beat counter SHALL clear to 0.
REQ-023 While in GRANT, changes on other req bits SHALL NOT affect sel.
REQ-024 A grant holder that keeps req high with dout_ready low SHALL keep the grant indefinitely (no timeout).
REQ-025 Every GRANT-to-IDLE transition SHALL insert exactly one IDLE cycle before the next grant.
REQ-026 The beat counter SHALL be 4 bits wide and SHALL never exceed MAX_HOLD.

Reset
REQ-027 While reset is high, regardless of clk, the block SHALL force:
  - state to IDLE
  - ptr, sel and beat count to 0
  - ack, dout_valid and busy to 0
  - dout to all zeros.
REQ-028 A reset asserted mid-GRANT SHALL abort the grant without producing an ack.
REQ-029 After reset deasserts, arbitration SHALL restart from ptr=0.

Structure
REQ-030 A shared package rr_arb4_pkg SHALL hold the state enum {IDLE, GRANT}, the constant NREQ=4 and the constant CNT_W=4.
REQ-031 The W-bit 4:1 data selection SHALL live in one sub-module, rr_arb4_mux (din_0..din_3, sel -> dout); the controller SHALL contain no data-path logic.

Verification
REQ-032 Reset, then req=4'b0100 held and dout_ready=1 -> grant at cycle 2 with sel=2; 4 acks 4'b0100; release to IDLE; ptr=3; re-grant to 2 after one IDLE cycle.
REQ-033 req=4'b1111 held, dout_ready=1, MAX_HOLD=4 -> grants in order sel 0,1,2,3,0, each exactly 4 beats.
REQ-034 Grant to 1, dout_ready=0 for 10 cycles, then req[1] drops -> no ack; dout_valid falls with req[1]; IDLE next edge; ptr=2.
REQ-035 Grant to 3 ends -> ptr wraps to 0; with req=4'b1001, next grant goes to 0.
REQ-036 Reset asserted asynchronously mid-GRANT after 2 beats -> outputs zero immediately, no further ack; after release, req=4'b0010 -> grant to 1.
REQ-037 din_i=i*0x11 with req=4'b1111 -> each acked beat shows dout equal to din_sel.
